rf_wr_arbiter: RTL and testbench

Write-port controller for the 32x32 register file. It shares the file's single write port between two requesters: requester 0 is core writeback and requester 1 is the load/debug path. Each requester has a valid/ready handshake, and grants alternate round-robin when both request. After reset it can sequence a zero-fill of every register before accepting requests. It drives the register file's `rg_wrt_en`, `rg_wrt_dest` and `rg_wrt_data` inputs from registers, and the register file's own synchronous reset is then tied low.

---
 rtl/rf_wr_if.sv | 33 +++
 rtl/rf_wr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rf_wr_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rf_wr_if.sv
// Write-port bundle between the two register-file requesters, the arbiter and the register file.
// The slave modport is the arbiter's view; the master modport is the requester/observer view.
interface rf_wr_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              rq0_valid;
    logic              rq0_ready;
    logic [ADDR_W-1:0] rq0_dest;
    logic [DATA_W-1:0] rq0_data;
    logic              rq1_valid;
    logic              rq1_ready;
    logic [ADDR_W-1:0] rq1_dest;
    logic [DATA_W-1:0] rq1_data;
    logic              rg_wrt_en;
    logic [ADDR_W-1:0] rg_wrt_dest;
    logic [DATA_W-1:0] rg_wrt_data;
    logic              init_done;

    modport master (
        output rq0_valid, rq0_dest, rq0_data,
        output rq1_valid, rq1_dest, rq1_data,
        input  rq0_ready, rq1_ready,
        input  rg_wrt_en, rg_wrt_dest, rg_wrt_data, init_done
    );

    modport slave (
        input  rq0_valid, rq0_dest, rq0_data,
        input  rq1_valid, rq1_dest, rq1_data,
        output rq0_ready, rq1_ready,
        output rg_wrt_en, rg_wrt_dest, rg_wrt_data, init_done
    );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Round-robin write-port arbiter for the 32x32 register file with registered write outputs.
// Define RF_INIT_SEQ_EN to build the post-reset zero-fill sequencer (INIT state and counter).
module rf_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic   clk,
    input  logic   rst,
    rf_wr_if.slave bus
);

    if (NREG != (1 << ADDR_W)) begin : g_nreg_check
        $error("rf_wr_arbiter: NREG must equal 2**ADDR_W");
    end

    logic              g0_s;
    logic              g1_s;
    logic              arb_s;
    logic              done_nxt_s;
    logic              last_grant_r;
    logic              last_grant_nxt_s;
    logic              en_r;
    logic              en_nxt_s;
    logic [ADDR_W-1:0] dest_r;
    logic [ADDR_W-1:0] dest_nxt_s;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] data_nxt_s;
    logic              done_r;

`ifdef RF_INIT_SEQ_EN
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);
    localparam logic              DONE_RST = 1'b0;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;

    // State and zero-fill counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_INIT;
            cnt_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next state: sweep every register once, then settle in ARB for good
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_INIT: begin
                cnt_nxt_s = cnt_r + ADDR_W'(1);
                if (cnt_r == LAST_IDX) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_ARB:  state_nxt_s = ST_ARB;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    assign arb_s      = (state_r == ST_ARB);
    assign done_nxt_s = (state_nxt_s == ST_ARB);
`else
    localparam logic DONE_RST = 1'b1;

    assign arb_s      = 1'b1;
    assign done_nxt_s = 1'b1;
`endif

    // Grant: a lone requester wins; on a tie the one not granted last time wins
    always_comb begin
        g0_s = 1'b0;
        g1_s = 1'b0;
        if (arb_s) begin
            case ({bus.rq1_valid, bus.rq0_valid})
                2'b01: g0_s = 1'b1;
                2'b10: g1_s = 1'b1;
                2'b11: begin
                    if (last_grant_r) begin
                        g0_s = 1'b1;
                    end else begin
                        g1_s = 1'b1;
                    end
                end
                default: begin
                    g0_s = 1'b0;
                    g1_s = 1'b0;
                end
            endcase
        end else begin
            g0_s = 1'b0;
            g1_s = 1'b0;
        end
    end

    // Next write-port contents; writes to x0 are consumed but never enabled
    always_comb begin
        en_nxt_s         = 1'b0;
        dest_nxt_s       = dest_r;
        data_nxt_s       = data_r;
        last_grant_nxt_s = last_grant_r;
`ifdef RF_INIT_SEQ_EN
        if (!arb_s) begin
            en_nxt_s   = 1'b1;
            dest_nxt_s = cnt_r;
            data_nxt_s = {DATA_W{1'b0}};
        end else
`endif
        if (g0_s) begin
            en_nxt_s         = (bus.rq0_dest != {ADDR_W{1'b0}});
            dest_nxt_s       = bus.rq0_dest;
            data_nxt_s       = bus.rq0_data;
            last_grant_nxt_s = 1'b0;
        end else if (g1_s) begin
            en_nxt_s         = (bus.rq1_dest != {ADDR_W{1'b0}});
            dest_nxt_s       = bus.rq1_dest;
            data_nxt_s       = bus.rq1_data;
            last_grant_nxt_s = 1'b1;
        end else begin
            en_nxt_s = 1'b0;
        end
    end

    // Registered write port, grant history and init_done flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r         <= 1'b0;
            dest_r       <= {ADDR_W{1'b0}};
            data_r       <= {DATA_W{1'b0}};
            last_grant_r <= 1'b1;
            done_r       <= DONE_RST;
        end else begin
            en_r         <= en_nxt_s;
            dest_r       <= dest_nxt_s;
            data_r       <= data_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            done_r       <= done_nxt_s;
        end
    end

    assign bus.rq0_ready   = g0_s;
    assign bus.rq1_ready   = g1_s;
    assign bus.rg_wrt_en   = en_r;
    assign bus.rg_wrt_dest = dest_r;
    assign bus.rg_wrt_data = data_r;
    assign bus.init_done   = done_r;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed self-checking bench for rf_wr_arbiter; adapts to builds with or without RF_INIT_SEQ_EN.
module tb_rf_wr_arbiter;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    rf_wr_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    rf_wr_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string tag, input logic en, input logic [4:0] dest,
                            input logic [31:0] data);
        chk({tag, "_en"}, {31'd0, bus.rg_wrt_en}, {31'd0, en});
        chk({tag, "_dest"}, {27'd0, bus.rg_wrt_dest}, {27'd0, dest});
        chk({tag, "_data"}, bus.rg_wrt_data, data);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.rq0_valid = 1'b1;
        bus.rq0_dest  = 5'd3;
        bus.rq0_data  = 32'h0000_00A3;
        bus.rq1_valid = 1'b1;
        bus.rq1_dest  = 5'd4;
        bus.rq1_data  = 32'h0000_00B4;
        #2;
        chk_port("reset", 1'b0, 5'd0, 32'd0);
`ifdef RF_INIT_SEQ_EN
        chk("reset_done", {31'd0, bus.init_done}, 32'd0);
        rst = 1'b0;
        // Zero-fill sweep with both requesters already waiting
        for (int k = 0; k < 32; k++) begin
            chk("init_rdy0", {31'd0, bus.rq0_ready}, 32'd0);
            chk("init_rdy1", {31'd0, bus.rq1_ready}, 32'd0);
            tick();
            chk_port("init", 1'b1, 5'(k), 32'd0);
            chk("init_done", {31'd0, bus.init_done}, (k == 31) ? 32'd1 : 32'd0);
        end
`else
        chk("reset_done", {31'd0, bus.init_done}, 32'd1);
        rst = 1'b0;
        #1;
`endif
        // Contention: first tie goes to requester 0, then strict alternation
        for (int i = 0; i < 4; i++) begin
            chk("cont_rdy0", {31'd0, bus.rq0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_rdy1", {31'd0, bus.rq1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            if (i % 2 == 0) chk_port("cont", 1'b1, 5'd3, 32'h0000_00A3);
            else            chk_port("cont", 1'b1, 5'd4, 32'h0000_00B4);
        end

        // Single requester 0 to register 9
        bus.rq1_valid = 1'b0;
        bus.rq0_dest  = 5'd9;
        bus.rq0_data  = 32'h0000_000F;
        #1;
        chk("single_rdy0", {31'd0, bus.rq0_ready}, 32'd1);
        chk("single_rdy1", {31'd0, bus.rq1_ready}, 32'd0);
        tick();
        chk_port("single", 1'b1, 5'd9, 32'h0000_000F);
        bus.rq0_valid = 1'b0;
        #1;
        chk("idle_rdy0", {31'd0, bus.rq0_ready}, 32'd0);
        tick();
        chk_port("idle", 1'b0, 5'd9, 32'h0000_000F);

        // Write to x0 from requester 1 is accepted but suppressed
        bus.rq1_valid = 1'b1;
        bus.rq1_dest  = 5'd0;
        bus.rq1_data  = 32'hDEAD_BEEF;
        #1;
        chk("x0_rdy1", {31'd0, bus.rq1_ready}, 32'd1);
        tick();
        chk_port("x0", 1'b0, 5'd0, 32'hDEAD_BEEF);
        // last_grant is now 1, so a tie must go to requester 0
        bus.rq0_valid = 1'b1;
        bus.rq0_dest  = 5'd3;
        bus.rq0_data  = 32'h0000_00A3;
        #1;
        chk("x0_tie_rdy0", {31'd0, bus.rq0_ready}, 32'd1);
        chk("x0_tie_rdy1", {31'd0, bus.rq1_ready}, 32'd0);
        tick();
        chk_port("x0_tie", 1'b1, 5'd3, 32'h0000_00A3);
        bus.rq0_valid = 1'b0;
        bus.rq1_valid = 1'b0;

        // Asynchronous reset while a write is pending in the output registers
        rst = 1'b1;
        #1;
        chk_port("rst_mid", 1'b0, 5'd0, 32'd0);
`ifdef RF_INIT_SEQ_EN
        rst = 1'b0;
        for (int k = 0; k < 18; k++) tick();
        chk_port("reinit17", 1'b1, 5'd17, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_port("rst_init", 1'b0, 5'd0, 32'd0);
        chk("rst_init_done", {31'd0, bus.init_done}, 32'd0);
        rst = 1'b0;
        tick();
        chk_port("restart", 1'b1, 5'd0, 32'd0);
        chk("restart_done", {31'd0, bus.init_done}, 32'd0);
`else
        // Request present during reset is written right after release
        bus.rq0_valid = 1'b1;
        bus.rq0_dest  = 5'd5;
        bus.rq0_data  = 32'h0000_0055;
        #1;
        chk("rst_done", {31'd0, bus.init_done}, 32'd1);
        rst = 1'b0;
        tick();
        chk_port("post_rst", 1'b1, 5'd5, 32'h0000_0055);
        bus.rq0_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_port("rst_pend", 1'b0, 5'd0, 32'd0);
        rst = 1'b0;
        tick();
        chk_port("post_rst_idle", 1'b0, 5'd0, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
